// File: rtl/tpx3_shutter_seq_pkg.sv
// tpx3_shutter_seq_pkg: shared widths and sequencer state encoding
package tpx3_shutter_seq_pkg;
   localparam int TPX3_CNT_WIDTH = 32;
   localparam int TPX3_REP_WIDTH = 16;
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_T0,
      ST_DELAY,
      ST_OPEN,
      ST_GAP,
      ST_FIN
   } state_t;
endpackage

// File: rtl/tpx3_seq_timer.sv
// tpx3_seq_timer: loadable down-counter, expired when it reaches zero
module tpx3_seq_timer #(
   parameter int W = 32
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_load,
   input  logic         i_ce,
   input  logic [W-1:0] i_value,
   output logic         o_expired
);
   logic [W-1:0] r_cnt;
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_cnt <= '0;
      else if (i_load) r_cnt <= i_value;
      else if (i_ce && r_cnt != '0) r_cnt <= r_cnt - W'(1);
   end
   assign o_expired = (r_cnt == '0);
endmodule

// File: rtl/tpx3_shutter_seq.sv
// tpx3_shutter_seq: Timepix3 shutter / T0_Sync frame sequencer
module tpx3_shutter_seq
   import tpx3_shutter_seq_pkg::*;
#(
   parameter int CNT_WIDTH = TPX3_CNT_WIDTH,
   parameter int REP_WIDTH = TPX3_REP_WIDTH
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 START,
   input  logic                 STOP,
   input  logic                 CONF_T0_EN,
   input  logic [CNT_WIDTH-1:0] CONF_DELAY,
   input  logic [CNT_WIDTH-1:0] CONF_WIDTH,
   input  logic [CNT_WIDTH-1:0] CONF_GAP,
   input  logic [REP_WIDTH-1:0] CONF_REPEAT,
   output logic                 SHUTTER,
   output logic                 T0_SYNC,
   output logic                 BUSY,
   output logic                 DONE,
   output logic [REP_WIDTH-1:0] FRAME_CNT
);
   state_t               r_state, w_next;
   logic [CNT_WIDTH-1:0] r_delay, r_width, r_gap;
   logic [REP_WIDTH-1:0] r_repeat, r_fc, w_fc_inc;
   logic [CNT_WIDTH-1:0] w_delay, w_width, w_gap, w_tval;
   logic                 r_shutter, r_t0, r_busy, r_done;
   logic                 w_shutter, w_t0, w_busy, w_done;
   logic                 w_go, w_exp, w_last, w_abort;
   // In IDLE the config is not latched yet, so timer loads must see the inputs
   assign w_delay  = (r_state == ST_IDLE) ? CONF_DELAY : r_delay;
   assign w_width  = (r_state == ST_IDLE) ? CONF_WIDTH : r_width;
   assign w_gap    = (r_state == ST_IDLE) ? CONF_GAP : r_gap;
   assign w_go     = (r_state == ST_IDLE) && START && !STOP;
   assign w_fc_inc = (r_fc == '1) ? r_fc : r_fc + REP_WIDTH'(1);
   assign w_last   = (r_repeat != '0) && (w_fc_inc == r_repeat);
   assign w_abort  = STOP && (r_state inside {ST_T0, ST_DELAY, ST_OPEN, ST_GAP});
   // Durations of zero still occupy one cycle, hence the clamp before the -1
   assign w_tval   = (w_next == ST_DELAY) ? w_delay - CNT_WIDTH'(1) :
                     (w_next == ST_OPEN)  ? ((w_width == '0) ? '0 : w_width - CNT_WIDTH'(1)) :
                                            ((w_gap == '0) ? '0 : w_gap - CNT_WIDTH'(1));
   tpx3_seq_timer #(.W(CNT_WIDTH)) u_timer (
      .i_clk     (CLK),
      .i_rst     (RST),
      .i_load    (w_next != r_state),
      .i_ce      (r_busy),
      .i_value   (w_tval),
      .o_expired (w_exp)
   );
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state   <= ST_IDLE;
         r_shutter <= 1'b0;
         r_t0      <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_shutter <= w_shutter;
         r_t0      <= w_t0;
         r_busy    <= w_busy;
         r_done    <= w_done;
      end
   end
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  if (w_go) w_next = CONF_T0_EN ? ST_T0 : ((CONF_DELAY != '0) ? ST_DELAY : ST_OPEN);
         ST_T0:    w_next = (r_delay != '0) ? ST_DELAY : ST_OPEN;
         ST_DELAY: if (w_exp) w_next = ST_OPEN;
         ST_OPEN:  if (w_exp) w_next = w_last ? ST_FIN : ST_GAP;
         ST_GAP:   if (w_exp) w_next = ST_OPEN;
         default:  w_next = ST_IDLE;
      endcase
      if (w_abort) w_next = ST_FIN;
   end
   always_comb begin
      w_shutter = (w_next == ST_OPEN);
      w_t0      = (w_next == ST_T0);
      w_busy    = !(w_next inside {ST_IDLE, ST_FIN});
      w_done    = (w_next == ST_FIN);
   end
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_delay  <= '0;
         r_width  <= '0;
         r_gap    <= '0;
         r_repeat <= '0;
         r_fc     <= '0;
      end else if (w_go) begin
         r_delay  <= CONF_DELAY;
         r_width  <= CONF_WIDTH;
         r_gap    <= CONF_GAP;
         r_repeat <= CONF_REPEAT;
         r_fc     <= '0;
      end else if (r_state == ST_OPEN && w_exp && !STOP) begin
         r_fc     <= w_fc_inc;
      end
   end
   assign SHUTTER   = r_shutter;
   assign T0_SYNC   = r_t0;
   assign BUSY      = r_busy;
   assign DONE      = r_done;
   assign FRAME_CNT = r_fc;
endmodule
